gfx_scheduler: RTL and testbench
================================

GFX_SCHEDULER -- requirements
Module: gfx_scheduler

Interface
REQ-001 Parameter DEPTH, 4, command FIFO entries; SHALL be a power of two, 2..16.
REQ-002 Ports SHALL be as follows (clock and reset first):
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- req0_valid  in  1  requester 0 offers a command
- req0_cmd  in  70  requester 0 command {opcode, tl_x[9:0], tl_y[8:0], br_x[9:0], br_y[8:0], arg[11:0], rom_addr[18:0]}
- req0_ready  out  1  requester 0 command accepted this cycle
- req1_valid, req1_cmd, req1_ready  in/in/out  1/70/1  requester 1, same meaning as requester 0
- gp_en  out  1  graphics processor enable
- gp_opcode  out  1  0 = solid fill with arg, 1 = ROM blit from rom_addr
- gp_tl_x  out  10  top-left x
- gp_tl_y  out  9  top-left y
- gp_br_x  out  10  bottom-right x
- gp_br_y  out  9  bottom-right y
- gp_arg  out  12  RGB444 colour
- gp_rom_addr  out  19  ROM base address
- gp_finish  in  1  graphics processor done (level)
- cmd_done  out  1  one-cycle pulse per completed command
- cmd_drop  out  1  one-cycle pulse per rejected command
- fifo_count  out  5  current FIFO occupancy
- idle  out  1  FIFO empty and FSM in IDLE

Function
REQ-003 Push arbitration SHALL accept at most one command per cycle; a command is accepted when valid and ready are both high.
REQ-004 readyN SHALL be combinational and asserted only when the FIFO is not full, reqN_valid=1, and N wins arbitration.
REQ-005 Arbitration SHALL be round-robin: with both requesters valid, the one not granted most recently wins; a lone valid requester always wins.
REQ-006 When the FIFO is full, both ready outputs SHALL be low, even if a pop occurs in the same cycle.
REQ-007 The FSM SHALL have three states: IDLE, RUN and GAP.
REQ-008 IDLE: when fifo_count>0, pop the head at the next edge, register it onto the gp_* fields, and enter RUN with gp_en=1.
REQ-009 IDLE, rejected head: if the popped head has tl_x>br_x, tl_y>br_y, br_x>639 or br_y>479, the FSM SHALL discard it, pulse cmd_drop for one cycle and stay in IDLE.
REQ-010 RUN: gp_en=1 and all gp_* fields held stable; on gp_finish=1, go to GAP.
REQ-011 GAP: gp_en=0 for exactly one cycle and cmd_done=1 for that cycle, then return to IDLE.
REQ-012 gp_finish SHALL be ignored in IDLE and GAP.
REQ-013 Latency: after a push is accepted at edge E into an empty FIFO with the FSM in IDLE, gp_en SHALL rise after edge E+1.
REQ-014 Back-to-back commands: consecutive gp_en high periods SHALL be separated by at least 2 low cycles (GAP plus the IDLE pop).
REQ-015 Simultaneous push and pop SHALL be supported; fifo_count is unchanged in that cycle.
REQ-016 FIFO pointers SHALL wrap modulo DEPTH; fifo_count SHALL never exceed DEPTH.
REQ-017 Commands SHALL issue in strict FIFO order.
REQ-018 idle SHALL equal (state==IDLE && fifo_count==0).

Reset
REQ-019 While rst_n=0 (asynchronous), the following SHALL hold: state=IDLE, FIFO empty, fifo_count=0, round-robin favours requester 0, gp_en=0, all gp_* fields=0, cmd_done=0, cmd_drop=0, idle=1.
REQ-020 Reset asserted during RUN SHALL drop gp_en immediately; the in-flight command and all queued commands are lost, with no cmd_done pulse.

Structure
REQ-021 Package gfx_pkg SHALL hold the command field widths, the 70-bit command layout/offsets, the screen limits (MAX_X=639, MAX_Y=479) and the state encoding.
REQ-022 The FIFO SHALL be a separate sub-module, gfx_cmd_fifo, parameterised by DEPTH and width.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Single fill {op0, 0,0, 639,479, arg 555} on req0; gp_finish raised 10 cycles after gp_en -> gp_en high 2 cycles after acceptance, fields match, one cmd_done, idle returns to 1.
- req0 and req1 valid continuously, finish after 3 cycles -> grants alternate 0,1,0,1; fifo_count caps at 4; both ready low while full.
- Six commands queued, finish after 1 cycle each -> issue order equals acceptance order; each en pulse separated by at least 2 low cycles.
- Command with tl_x=100, br_x=50 -> cmd_drop pulse, gp_en stays 0, next valid command still issues.
- rst_n low for 1 cycle mid-RUN with 3 queued -> gp_en low asynchronously, fifo_count=0, no cmd_done.
- gp_finish held high while IDLE/GAP -> no spurious state change and no extra cmd_done.

Source files
------------

// File: rtl/gfx_pkg.sv
// gfx_pkg: shared definitions for the graphics command scheduler.
//   - command field widths and the 70-bit command layout
//     {opcode, tl_x, tl_y, br_x, br_y, arg, rom_addr} (opcode is the MSB)
//   - screen limits used to reject out-of-range rectangles
//   - FSM state encoding
package gfx_pkg;
  localparam int OP_W  = 1;
  localparam int X_W   = 10;
  localparam int Y_W   = 9;
  localparam int ARG_W = 12;
  localparam int ROM_W = 19;
  localparam int CMD_W = OP_W + 2*X_W + 2*Y_W + ARG_W + ROM_W;  // 70

  // Bit offsets (LSB) of each field inside the packed command word.
  localparam int ROM_LSB = 0;
  localparam int ARG_LSB = ROM_LSB + ROM_W;   // 19
  localparam int BRY_LSB = ARG_LSB + ARG_W;   // 31
  localparam int BRX_LSB = BRY_LSB + Y_W;     // 40
  localparam int TLY_LSB = BRX_LSB + X_W;     // 50
  localparam int TLX_LSB = TLY_LSB + Y_W;     // 59
  localparam int OP_LSB  = TLX_LSB + X_W;     // 69

  localparam int MAX_X = 639;
  localparam int MAX_Y = 479;

  typedef struct packed {
    logic             op;
    logic [X_W-1:0]   tl_x;
    logic [Y_W-1:0]   tl_y;
    logic [X_W-1:0]   br_x;
    logic [Y_W-1:0]   br_y;
    logic [ARG_W-1:0] arg;
    logic [ROM_W-1:0] rom_addr;
  } gfx_cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2
  } gfx_state_e;

  // A rectangle is usable only if it is non-inverted and fits on screen.
  function automatic logic cmd_in_bounds(input gfx_cmd_t c);
    return (c.tl_x <= c.br_x) && (c.tl_y <= c.br_y) &&
           (c.br_x <= X_W'(MAX_X)) && (c.br_y <= Y_W'(MAX_Y));
  endfunction
endpackage

// File: rtl/gfx_cmd_fifo.sv
// gfx_cmd_fifo: synchronous FIFO, DEPTH entries (power of two) of WIDTH bits.
//   clk, rst_n      : clock, async active-low reset (pointers/count only)
//   push, din       : write (ignored when full)
//   pop             : read/discard head (ignored when empty)
//   dout            : head entry, valid while !empty (show-ahead)
//   count           : occupancy 0..DEPTH
//   full, empty     : occupancy flags
module gfx_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 70,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Pointers are exactly AW bits wide, so they wrap modulo DEPTH for free.
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end
endmodule

// File: rtl/gfx_scheduler.sv
// gfx_scheduler: two-requester round-robin command queue feeding a
// graphics processor one command at a time.
//   clk, rst_n                  : clock, async active-low reset
//   reqN_valid/reqN_cmd/ready   : requester push ports (N = 0, 1)
//   gp_en, gp_*                 : command presented to the processor
//   gp_finish                   : processor done (level, honoured in RUN)
//   cmd_done / cmd_drop         : one-cycle completion / rejection pulses
//   fifo_count, idle            : status
module gfx_scheduler
  import gfx_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [CMD_W-1:0] req0_cmd,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [CMD_W-1:0] req1_cmd,
  output logic             req1_ready,
  output logic             gp_en,
  output logic             gp_opcode,
  output logic [X_W-1:0]   gp_tl_x,
  output logic [Y_W-1:0]   gp_tl_y,
  output logic [X_W-1:0]   gp_br_x,
  output logic [Y_W-1:0]   gp_br_y,
  output logic [ARG_W-1:0] gp_arg,
  output logic [ROM_W-1:0] gp_rom_addr,
  input  logic             gp_finish,
  output logic             cmd_done,
  output logic             cmd_drop,
  output logic [4:0]       fifo_count,
  output logic             idle
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [CMD_W-1:0] push_cmd, head_raw;
  logic [CW-1:0]    cnt;
  logic             full, empty, push, pop, grant1;
  gfx_cmd_t         head;
  gfx_state_e       state_q, state_d;
  gfx_cmd_t         gp_q, gp_d;
  logic             rr1_q, rr1_d;    // 1: requester 1 wins a tie next
  logic             drop_q, drop_d;

  gfx_cmd_fifo #(.DEPTH(DEPTH), .WIDTH(CMD_W)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (push_cmd),
    .pop   (pop),
    .dout  (head_raw),
    .count (cnt),
    .full  (full),
    .empty (empty)
  );

  assign head = gfx_cmd_t'(head_raw);

  // Push arbitration. Readiness depends on full only, not on a same-cycle
  // pop, so ready never has a combinational path from the FSM.
  always_comb begin
    grant1     = req1_valid && (!req0_valid || rr1_q);
    req0_ready = !full && req0_valid && !grant1;
    req1_ready = !full && req1_valid && grant1;
    push       = req0_ready || req1_ready;
    push_cmd   = grant1 ? req1_cmd : req0_cmd;
    rr1_d      = push ? !grant1 : rr1_q;
  end

  always_comb begin
    state_d = state_q;
    gp_d    = gp_q;
    drop_d  = 1'b0;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          if (cmd_in_bounds(head)) begin
            gp_d    = head;
            state_d = ST_RUN;
          end else begin
            drop_d = 1'b1;
          end
        end
      end
      ST_RUN:  if (gp_finish) state_d = ST_GAP;
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gp_q    <= '0;
      rr1_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gp_q    <= gp_d;
      rr1_q   <= rr1_d;
      drop_q  <= drop_d;
    end
  end

  // Status decoded straight from the state flop so reset clears gp_en at once.
  assign gp_en       = (state_q == ST_RUN);
  assign cmd_done    = (state_q == ST_GAP);
  assign cmd_drop    = drop_q;
  assign idle        = (state_q == ST_IDLE) && empty;
  assign fifo_count  = 5'(cnt);
  assign gp_opcode   = gp_q.op;
  assign gp_tl_x     = gp_q.tl_x;
  assign gp_tl_y     = gp_q.tl_y;
  assign gp_br_x     = gp_q.br_x;
  assign gp_br_y     = gp_q.br_y;
  assign gp_arg      = gp_q.arg;
  assign gp_rom_addr = gp_q.rom_addr;
endmodule

// File: tb/tb_gfx_scheduler.sv
// tb_gfx_scheduler: directed scenarios plus randomized traffic, checked every
// cycle against a queue-based behavioural model and a scoreboard of accepted
// commands.
module tb_gfx_scheduler;
  localparam int DEPTH = 4;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [69:0] req0_cmd = '0, req1_cmd = '0;
  logic        req0_ready, req1_ready;
  logic        gp_en, gp_opcode;
  logic [9:0]  gp_tl_x, gp_br_x;
  logic [8:0]  gp_tl_y, gp_br_y;
  logic [11:0] gp_arg;
  logic [18:0] gp_rom_addr;
  logic        gp_finish = 1'b0;
  logic        cmd_done, cmd_drop, idle;
  logic [4:0]  fifo_count;

  gfx_scheduler #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_cmd(req0_cmd), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_cmd(req1_cmd), .req1_ready(req1_ready),
    .gp_en(gp_en), .gp_opcode(gp_opcode), .gp_tl_x(gp_tl_x), .gp_tl_y(gp_tl_y),
    .gp_br_x(gp_br_x), .gp_br_y(gp_br_y), .gp_arg(gp_arg),
    .gp_rom_addr(gp_rom_addr), .gp_finish(gp_finish), .cmd_done(cmd_done),
    .cmd_drop(cmd_drop), .fifo_count(fifo_count), .idle(idle)
  );

  initial forever #5 clk = ~clk;

  int errors = 0, checks = 0;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [69:0] mk(input bit op, input int tx, input int ty,
                                     input int bx, input int by, input int a, input int r);
    logic [9:0] tx10 = 10'(tx), bx10 = 10'(bx);
    logic [8:0] ty9 = 9'(ty), by9 = 9'(by);
    logic [11:0] a12 = 12'(a);
    logic [18:0] r19 = 19'(r);
    return {op, tx10, ty9, bx10, by9, a12, r19};
  endfunction

  function automatic bit bad(input logic [69:0] c);
    return (c[68:59] > c[49:40]) || (c[58:50] > c[39:31]) ||
           (c[49:40] > 10'd639) || (c[39:31] > 9'd479);
  endfunction

  // ---------------- behavioural model ----------------
  logic [69:0] m_q[$];
  int          m_phase;   // 0 idle, 1 processor running, 2 gap cycle
  logic [69:0] m_cur;
  bit          m_pri1, m_drop;

  task automatic model_reset();
    m_q.delete(); m_phase = 0; m_cur = '0; m_pri1 = 0; m_drop = 0;
  endtask

  task automatic model_step();
    bit full, w1;
    logic [69:0] h;
    if (!rst_n) begin model_reset(); return; end
    full = (m_q.size() == DEPTH);
    w1   = (req0_valid && req1_valid) ? m_pri1 : req1_valid;
    m_drop = 0;
    if (m_phase == 0) begin
      if (m_q.size() > 0) begin
        h = m_q.pop_front();
        if (bad(h)) m_drop = 1;
        else begin m_cur = h; m_phase = 1; end
      end
    end else if (m_phase == 1) begin
      if (gp_finish) m_phase = 2;
    end else m_phase = 0;
    if (!full && (req0_valid || req1_valid)) begin
      m_q.push_back(w1 ? req1_cmd : req0_cmd);
      m_pri1 = !w1;
    end
  endtask

  bit mon_on = 0;
  initial begin model_reset(); forever begin @(posedge clk); model_step(); end end
  initial forever begin @(negedge rst_n); model_reset(); end

  // Per-cycle comparison against the model.
  initial begin
    bit full, w1;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        full = (m_q.size() == DEPTH);
        w1   = (req0_valid && req1_valid) ? m_pri1 : req1_valid;
        chk("req0_ready", req0_ready, !full && req0_valid && !w1);
        chk("req1_ready", req1_ready, !full && req1_valid && w1);
        chk("gp_en", gp_en, m_phase == 1);
        chk("cmd_done", cmd_done, m_phase == 2);
        chk("cmd_drop", cmd_drop, m_drop);
        chk("fifo_count", fifo_count, m_q.size());
        chk("idle", idle, m_phase == 0 && m_q.size() == 0);
        chk("gp_fields", {gp_opcode, gp_tl_x, gp_tl_y, gp_br_x, gp_br_y, gp_arg, gp_rom_addr}, m_cur);
      end
    end
  end

  // ---------------- scoreboard / protocol monitor ----------------
  logic [69:0] acc_log[$];
  int grant_log[$];
  int cyc = 0, acc_cyc = 0, en_rise_cyc = 0, low_run = 0, max_cnt = 0;
  int ndone = 0, ndrop = 0, niss = 0;
  bit en_prev = 0, seen_en = 0;

  initial forever begin
    @(negedge clk);
    cyc++;
    if (!rst_n) begin
      acc_log.delete(); seen_en = 0; en_prev = 0; low_run = 0;
      continue;
    end
    if (!mon_on) continue;
    if (req0_valid && req0_ready) begin acc_log.push_back(req0_cmd); grant_log.push_back(0); acc_cyc = cyc; end
    if (req1_valid && req1_ready) begin acc_log.push_back(req1_cmd); grant_log.push_back(1); acc_cyc = cyc; end
    if (cmd_drop) begin
      ndrop++;
      chk("drop_has_cmd", acc_log.size() > 0, 1'b1);
      if (acc_log.size() > 0) chk("drop_cmd_is_bad", bad(acc_log.pop_front()), 1'b1);
    end
    if (gp_en && !en_prev) begin
      niss++; en_rise_cyc = cyc;
      chk("issue_has_cmd", acc_log.size() > 0, 1'b1);
      if (acc_log.size() > 0)
        chk("issue_order", {gp_opcode, gp_tl_x, gp_tl_y, gp_br_x, gp_br_y, gp_arg, gp_rom_addr},
            acc_log.pop_front());
      if (seen_en) chk("gap_low_cycles", low_run >= 2, 1'b1);
      seen_en = 1;
    end
    if (cmd_done) ndone++;
    if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
    if (fifo_count == DEPTH) chk("ready_low_when_full", {req0_ready, req1_ready}, 2'b00);
    low_run = gp_en ? 0 : low_run + 1;
    en_prev = gp_en;
  end

  // ---------------- stimulus ----------------
  logic [69:0] src0[$], src1[$];
  bit rand_gate = 0, rand_fin = 0, force_fin = 0;
  int fin_delay = 1, en_cnt = 0;

  task automatic tick();
    bit a0, a1;
    @(negedge clk);
    a0 = req0_valid && req0_ready;
    a1 = req1_valid && req1_ready;
    if (gp_en) en_cnt++; else en_cnt = 0;
    @(posedge clk); #1;
    if (a0) void'(src0.pop_front());
    if (a1) void'(src1.pop_front());
    req0_valid = (src0.size() > 0) && (!rand_gate || $urandom_range(0, 3) != 0);
    req1_valid = (src1.size() > 0) && (!rand_gate || $urandom_range(0, 3) != 0);
    req0_cmd   = (src0.size() > 0) ? src0[0] : '0;
    req1_cmd   = (src1.size() > 0) ? src1[0] : '0;
    if (rand_fin && en_cnt == 0) fin_delay = $urandom_range(1, 5);
    gp_finish = force_fin || (en_cnt > 0 && en_cnt >= fin_delay);
  endtask

  task automatic run_until_idle(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      tick();
      if (src0.size() == 0 && src1.size() == 0 && idle && !gp_en) break;
    end
    chk("drain_before_budget", i < budget, 1'b1);
  endtask

  task automatic do_reset();
    rst_n = 0; req0_valid = 0; req1_valid = 0; gp_finish = 0; force_fin = 0;
    src0.delete(); src1.delete(); en_cnt = 0;
    @(negedge clk);
    chk("rst_gp_en", gp_en, 1'b0);
    chk("rst_fifo_count", fifo_count, 5'd0);
    chk("rst_idle", idle, 1'b1);
    chk("rst_pulses", {cmd_done, cmd_drop}, 2'b00);
    chk("rst_fields", {gp_opcode, gp_tl_x, gp_tl_y, gp_br_x, gp_br_y, gp_arg, gp_rom_addr}, 70'd0);
    @(posedge clk); #1;
    rst_n = 1; mon_on = 1;
  endtask

  function automatic logic [69:0] rand_cmd();
    int tx = $urandom_range(0, 600), ty = $urandom_range(0, 440);
    int bx = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 1023) : tx + $urandom_range(0, 39);
    int by = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 511) : ty + $urandom_range(0, 39);
    return mk(1'($urandom), tx, ty, bx, by, $urandom, $urandom);
  endfunction

  initial begin
    int d0, n0, p0;
    // 1: single full-screen fill
    do_reset();
    src0.push_back(mk(0, 0, 0, 639, 479, 'h555, 0));
    fin_delay = 10; d0 = ndone;
    run_until_idle(200);
    chk("s1_latency", en_rise_cyc - acc_cyc, 2);
    chk("s1_opcode", gp_opcode, 1'b0);
    chk("s1_tl", {gp_tl_x, gp_tl_y}, 19'd0);
    chk("s1_br_x", gp_br_x, 10'd639);
    chk("s1_br_y", gp_br_y, 9'd479);
    chk("s1_arg", gp_arg, 12'h555);
    chk("s1_done_count", ndone - d0, 1);
    chk("s1_idle", idle, 1'b1);

    // 2: both requesters streaming, round-robin and full handling
    do_reset();
    grant_log.delete(); max_cnt = 0; fin_delay = 3;
    for (int i = 0; i < 4; i++) begin
      src0.push_back(mk(0, i, i, 100 + i, 100, i, 0));
      src1.push_back(mk(1, 200 + i, i, 300, 200, 0, 1000 + i));
    end
    run_until_idle(400);
    for (int i = 0; i < 4; i++) chk("s2_grant_alternates", grant_log[i], i % 2);
    chk("s2_fifo_cap", max_cnt, DEPTH);

    // 3: six queued commands, short runs
    do_reset();
    fin_delay = 1; n0 = niss; d0 = ndone;
    for (int i = 0; i < 6; i++) src0.push_back(mk(i % 2, 10 * i, 5 * i, 10 * i + 7, 5 * i + 3, i, i));
    run_until_idle(300);
    chk("s3_issued", niss - n0, 6);
    chk("s3_done", ndone - d0, 6);

    // 4: inverted rectangle dropped, following command still issues
    do_reset();
    n0 = niss; p0 = ndrop;
    src0.push_back(mk(0, 100, 0, 50, 10, 1, 0));
    src0.push_back(mk(0, 1, 2, 3, 4, 5, 0));
    run_until_idle(200);
    chk("s4_drops", ndrop - p0, 1);
    chk("s4_issued", niss - n0, 1);

    // 5: reset mid-run with three queued
    do_reset();
    fin_delay = 1000; d0 = ndone;
    for (int i = 0; i < 4; i++) src0.push_back(mk(0, i, 0, i + 1, 1, 0, 0));
    for (int i = 0; i < 50 && !(gp_en && fifo_count == 3); i++) tick();
    chk("s5_setup_count", fifo_count, 5'd3);
    @(posedge clk); #3;
    rst_n = 0; req0_valid = 0; src0.delete();
    #1;
    chk("s5_async_en", gp_en, 1'b0);
    chk("s5_async_count", fifo_count, 5'd0);
    chk("s5_async_idle", idle, 1'b1);
    @(posedge clk); #3;
    rst_n = 1; fin_delay = 1;
    repeat (4) tick();
    chk("s5_no_done", ndone - d0, 0);

    // 6: gp_finish held high outside RUN
    do_reset();
    force_fin = 1; gp_finish = 1; d0 = ndone; n0 = niss;
    repeat (6) tick();
    chk("s6_no_spurious_done", ndone - d0, 0);
    chk("s6_idle", idle, 1'b1);
    src0.push_back(mk(1, 5, 5, 9, 9, 0, 'h1234));
    run_until_idle(100);
    chk("s6_one_done", ndone - d0, 1);
    chk("s6_one_issue", niss - n0, 1);
    force_fin = 0;

    // 7: randomized traffic
    do_reset();
    rand_gate = 1; rand_fin = 1;
    for (int b = 0; b < 80; b++) begin
      repeat ($urandom_range(0, 3)) src0.push_back(rand_cmd());
      repeat ($urandom_range(0, 3)) src1.push_back(rand_cmd());
      repeat ($urandom_range(0, 20)) tick();
    end
    run_until_idle(5000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
